mmio_periph: RTL and testbench



---
 rtl/mmio_periph_pkg.sv | 37 +++
 rtl/mmio_periph_uart_xcvr.sv | 131 +++++++++++++
 rtl/mmio_periph.sv | 158 +++++++++++++++
 tb/tb_mmio_periph.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mmio_periph_pkg.sv
// Shared definitions for the MMIO peripheral block: register offsets
// (word index taken from addr[5:2]), control/status bit positions and the
// UART state encoding used by both the transmitter and the receiver.
package mmio_periph_pkg;

  // Word offsets within the 0x4000_0000 peripheral window.
  localparam logic [3:0] TH_OFF       = 4'h0;
  localparam logic [3:0] TL_OFF       = 4'h1;
  localparam logic [3:0] TCON_OFF     = 4'h2;
  localparam logic [3:0] LED_OFF      = 4'h3;
  localparam logic [3:0] SWITCH_OFF   = 4'h4;
  localparam logic [3:0] DIGI_OFF     = 4'h5;
  localparam logic [3:0] UART_TXD_OFF = 4'h6;
  localparam logic [3:0] UART_RXD_OFF = 4'h7;
  localparam logic [3:0] UART_CON_OFF = 4'h8;

  // TCON bit positions.
  localparam int TCON_EN = 0;
  localparam int TCON_IE = 1;
  localparam int TCON_IP = 2;

  // UART_CON bit positions.
  localparam int UCON_TX_BUSY = 0;
  localparam int UCON_RX_BUSY = 1;
  localparam int UCON_RX_VLD  = 2;
  localparam int UCON_TX_OVR  = 3;
  localparam int UCON_RX_OVR  = 4;

  // Frame phases, shared by the TX and RX state machines.
  typedef enum logic [1:0] {
    UART_IDLE  = 2'd0,
    UART_START = 2'd1,
    UART_DATA  = 2'd2,
    UART_STOP  = 2'd3
  } uart_state_t;

endpackage

// File: rtl/mmio_periph_uart_xcvr.sv
// 8N1 UART transceiver: TX and RX state machines with their own baud
// counters, plus a two-flop synchroniser on the asynchronous RX line.
// rx_valid pulses for one cycle when a byte with a good stop bit lands.
module uart_xcvr
  import mmio_periph_pkg::*;
#(
  parameter int CLKS_PER_BIT = 10417,
  parameter int RX_SAMPLE    = CLKS_PER_BIT / 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tx_start,
  input  logic [7:0] tx_data,
  output logic       tx_busy,
  output logic       tx,
  input  logic       rx,
  output logic       rx_valid,
  output logic [7:0] rx_data,
  output logic       rx_busy
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] BIT_LAST    = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] SAMPLE_LAST = CNT_W'((RX_SAMPLE > 0) ? RX_SAMPLE - 1 : 0);

  uart_state_t      tx_state, rx_state;
  logic [CNT_W-1:0] tx_cnt, rx_cnt;
  logic [2:0]       tx_idx, rx_idx;
  logic [7:0]       tx_shift, rx_shift;
  logic             rx_s1, rx_s2, rx_prev;

  assign tx_busy = (tx_state != UART_IDLE);
  assign rx_busy = (rx_state != UART_IDLE);

  // TX frame sequencer; the line level is registered alongside the state.
  // NOTE: sequential state is assigned with <= so every flop sees pre-edge
  // values regardless of statement order; blocking here would create races.
  // The async reset also forces tx high the moment reset asserts.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tx_state <= UART_IDLE;
      tx_cnt   <= '0;
      tx_idx   <= '0;
      tx_shift <= '0;
      tx       <= 1'b1;
    end else begin
      case (tx_state)
        UART_IDLE: if (tx_start) begin
          tx_state <= UART_START;
          tx_cnt   <= '0;
          tx_shift <= tx_data;
          tx       <= 1'b0;
        end
        UART_START: if (tx_cnt == BIT_LAST) begin
          tx_cnt   <= '0;
          tx_idx   <= '0;
          tx       <= tx_shift[0];
          tx_state <= UART_DATA;
        end else tx_cnt <= tx_cnt + 1'b1;
        UART_DATA: if (tx_cnt == BIT_LAST) begin
          tx_cnt   <= '0;
          tx_idx   <= tx_idx + 1'b1;
          tx_shift <= {1'b0, tx_shift[7:1]};
          if (tx_idx == 3'd7) begin
            tx_state <= UART_STOP;
            tx       <= 1'b1;
          end else tx <= tx_shift[1];
        end else tx_cnt <= tx_cnt + 1'b1;
        UART_STOP: if (tx_cnt == BIT_LAST) begin
          tx_cnt   <= '0;
          tx_state <= UART_IDLE;
        end else tx_cnt <= tx_cnt + 1'b1;
        default: tx_state <= UART_IDLE;
      endcase
    end
  end

  // Two-flop synchroniser plus one delayed copy for falling-edge detection.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_s1   <= 1'b1;
      rx_s2   <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_s1   <= rx;
      rx_s2   <= rx_s1;
      rx_prev <= rx_s2;
    end
  end

  // RX frame sequencer: validate start bit mid-way, then sample mid-bit.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_state <= UART_IDLE;
      rx_cnt   <= '0;
      rx_idx   <= '0;
      rx_shift <= '0;
      rx_data  <= '0;
      rx_valid <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      case (rx_state)
        UART_IDLE: if (rx_prev && !rx_s2) begin
          rx_state <= UART_START;
          rx_cnt   <= '0;
        end
        UART_START: if (rx_cnt == SAMPLE_LAST) begin
          rx_cnt   <= '0;
          rx_idx   <= '0;
          rx_state <= rx_s2 ? UART_IDLE : UART_DATA;
        end else rx_cnt <= rx_cnt + 1'b1;
        UART_DATA: if (rx_cnt == BIT_LAST) begin
          rx_cnt   <= '0;
          rx_shift <= {rx_s2, rx_shift[7:1]};
          rx_idx   <= rx_idx + 1'b1;
          if (rx_idx == 3'd7) rx_state <= UART_STOP;
        end else rx_cnt <= rx_cnt + 1'b1;
        UART_STOP: if (rx_cnt == BIT_LAST) begin
          rx_cnt   <= '0;
          rx_state <= UART_IDLE;
          if (rx_s2) begin
            rx_data  <= rx_shift;
            rx_valid <= 1'b1;
          end
        end else rx_cnt <= rx_cnt + 1'b1;
        default: rx_state <= UART_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/mmio_periph.sv
// Memory-mapped peripheral block for the MEM stage: reloading timer with
// interrupt, LED/switch/7-segment registers and, when PERIPH_UART_EN is
// defined, an 8N1 UART. Without PERIPH_UART_EN the UART registers read 0,
// ignore writes, and uart_tx idles high.
module mmio_periph
  import mmio_periph_pkg::*;
#(
  parameter int CLKS_PER_BIT = 10417,
  parameter int RX_SAMPLE    = CLKS_PER_BIT / 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rd,
  input  logic        wr,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  input  logic        uart_rx,
  output logic        uart_tx,
  output logic [7:0]  led,
  input  logic [7:0]  switch,
  output logic [11:0] digi,
  output logic        irq,
  input  logic        supervisor
);

  logic [3:0]  off;
  logic        hit_rd, hit_wr;
  logic        we_th, we_tl, we_tcon, we_led, we_digi;
  logic [31:0] th, tl;
  logic [2:0]  tcon;
  logic        overflow;
  logic [7:0]  sw_s1, sw_s2;
  logic [7:0]  txd, rxd;
  logic [31:0] ucon;
  logic        unused_addr;

  assign off         = addr[5:2];
  assign hit_rd      = rd & addr[30];
  assign hit_wr      = wr & addr[30];
  assign we_th       = hit_wr && (off == TH_OFF);
  assign we_tl       = hit_wr && (off == TL_OFF);
  assign we_tcon     = hit_wr && (off == TCON_OFF);
  assign we_led      = hit_wr && (off == LED_OFF);
  assign we_digi     = hit_wr && (off == DIGI_OFF);
  assign overflow    = tcon[TCON_EN] && (tl == 32'hFFFF_FFFF);
  assign irq         = tcon[TCON_IE] & tcon[TCON_IP] & ~supervisor;
  assign unused_addr = ^{addr[31], addr[29:6], addr[1:0]};

  // Timer: a CPU write to TL or TCON overrides the same-cycle count/reload.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      th   <= '0;
      tl   <= '0;
      tcon <= '0;
    end else begin
      if (we_th) th <= wdata;
      if (we_tl) tl <= wdata;
      else if (tcon[TCON_EN]) tl <= overflow ? th : tl + 32'd1;
      if (we_tcon) tcon <= wdata[2:0];
      else if (overflow && tcon[TCON_IE]) tcon[TCON_IP] <= 1'b1;
    end
  end

  // Board I/O registers; switches are double-flopped as they are asynchronous.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      led   <= '0;
      digi  <= '0;
      sw_s1 <= '0;
      sw_s2 <= '0;
    end else begin
      if (we_led)  led  <= wdata[7:0];
      if (we_digi) digi <= wdata[11:0];
      sw_s1 <= switch;
      sw_s2 <= sw_s1;
    end
  end

`ifdef PERIPH_UART_EN
  logic       tx_start, tx_busy, rx_busy, rx_pulse;
  logic       rx_vld, tx_ovr, rx_ovr;
  logic       we_txd, we_con, rd_rxd;
  logic [7:0] rx_byte;

  assign we_txd   = hit_wr && (off == UART_TXD_OFF);
  assign we_con   = hit_wr && (off == UART_CON_OFF);
  assign rd_rxd   = hit_rd && (off == UART_RXD_OFF);
  assign tx_start = we_txd && !tx_busy;
  assign ucon     = {27'd0, rx_ovr, tx_ovr, rx_vld, rx_busy, tx_busy};

  uart_xcvr #(
    .CLKS_PER_BIT (CLKS_PER_BIT),
    .RX_SAMPLE    (RX_SAMPLE)
  ) u_xcvr (
    .clk      (clk),
    .reset    (reset),
    .tx_start (tx_start),
    .tx_data  (wdata[7:0]),
    .tx_busy  (tx_busy),
    .tx       (uart_tx),
    .rx       (uart_rx),
    .rx_valid (rx_pulse),
    .rx_data  (rx_byte),
    .rx_busy  (rx_busy)
  );

  // UART data/status registers; a freshly arrived byte beats a same-cycle read.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      txd    <= '0;
      rxd    <= '0;
      rx_vld <= 1'b0;
      tx_ovr <= 1'b0;
      rx_ovr <= 1'b0;
    end else begin
      if (tx_start) txd <= wdata[7:0];
      if (rx_pulse) rxd <= rx_byte;
      if (rx_pulse) rx_vld <= 1'b1;
      else if (rd_rxd) rx_vld <= 1'b0;
      if (we_txd && tx_busy) tx_ovr <= 1'b1;
      else if (we_con && !wdata[UCON_TX_OVR]) tx_ovr <= 1'b0;
      if (rx_pulse && rx_vld) rx_ovr <= 1'b1;
      else if (we_con && !wdata[UCON_RX_OVR]) rx_ovr <= 1'b0;
    end
  end
`else
  logic unused_rx;

  assign uart_tx   = 1'b1;
  assign txd       = '0;
  assign rxd       = '0;
  assign ucon      = '0;
  assign unused_rx = uart_rx;
`endif

  // Zero-latency read mux; unselected or unmapped reads return 0.
  // NOTE: rdata gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    rdata = '0;
    if (hit_rd) begin
      case (off)
        TH_OFF:       rdata = th;
        TL_OFF:       rdata = tl;
        TCON_OFF:     rdata = {29'd0, tcon};
        LED_OFF:      rdata = {24'd0, led};
        SWITCH_OFF:   rdata = {24'd0, sw_s2};
        DIGI_OFF:     rdata = {20'd0, digi};
        UART_TXD_OFF: rdata = {24'd0, txd};
        UART_RXD_OFF: rdata = {24'd0, rxd};
        UART_CON_OFF: rdata = ucon;
        default:      rdata = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_mmio_periph.sv
// Self-checking bench for mmio_periph with CLKS_PER_BIT=16. Expected values
// come from frame/timer arithmetic in the bench. UART sections follow the
// PERIPH_UART_EN build option of the design.
module tb_mmio_periph;
  import mmio_periph_pkg::*;

  localparam int CPB = 16;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        rd = 1'b0, wr = 1'b0;
  logic [31:0] addr = '0, wdata = '0;
  logic [31:0] rdata;
  logic        uart_rx = 1'b1;
  logic        uart_tx;
  logic [7:0]  led;
  logic [7:0]  switch = '0;
  logic [11:0] digi;
  logic        irq;
  logic        supervisor = 1'b0;

  int n_tests = 0;
  int n_fail  = 0;

  mmio_periph #(.CLKS_PER_BIT(CPB), .RX_SAMPLE(CPB / 2)) dut (
    .clk(clk), .reset(reset), .rd(rd), .wr(wr), .addr(addr), .wdata(wdata),
    .rdata(rdata), .uart_rx(uart_rx), .uart_tx(uart_tx), .led(led),
    .switch(switch), .digi(digi), .irq(irq), .supervisor(supervisor)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [3:0] off, input logic [31:0] d);
    wr = 1'b1; addr = 32'h4000_0000 | {26'd0, off, 2'b00}; wdata = d;
    tick();
    wr = 1'b0; addr = '0; wdata = '0;
  endtask

  // Combinational read within the current cycle; no clock edge is crossed.
  task automatic peek(input logic [3:0] off, output logic [31:0] d);
    rd = 1'b1; addr = 32'h4000_0000 | {26'd0, off, 2'b00};
    #1;
    d = rdata;
    rd = 1'b0; addr = '0;
  endtask

  // Read held across a clock edge, so read side effects take place.
  task automatic read_edge(input logic [3:0] off);
    rd = 1'b1; addr = 32'h4000_0000 | {26'd0, off, 2'b00};
    tick();
    rd = 1'b0; addr = '0;
  endtask

  task automatic check_all_zero(input string tag);
    logic [31:0] v;
    for (int o = 0; o < 10; o++) begin
      peek(4'(o), v);
      check(tag, v, 32'd0);
    end
    check({tag, "_tx"}, {31'd0, uart_tx}, 32'd1);
    check({tag, "_irq"}, {31'd0, irq}, 32'd0);
    check({tag, "_led"}, {24'd0, led}, 32'd0);
    check({tag, "_digi"}, {20'd0, digi}, 32'd0);
    tick();
  endtask

  // Sends one byte and checks the line bit by bit against the 8N1 frame.
  task automatic tx_frame(input logic [7:0] b, input bit overrun);
    logic [9:0]  frame;
    logic [31:0] v;
    frame = {1'b1, b, 1'b0};
    bus_write(UART_TXD_OFF, {24'd0, b});
    for (int t = 0; t <= 10 * CPB; t++) begin
      check("tx_line", {31'd0, uart_tx}, (t < 10 * CPB) ? {31'd0, frame[t / CPB]} : 32'd1);
      peek(UART_CON_OFF, v);
      check("tx_busy", {31'd0, v[UCON_TX_BUSY]}, (t < 10 * CPB) ? 32'd1 : 32'd0);
      if (t == 0) begin
        peek(UART_TXD_OFF, v);
        check("txd_read", v, {24'd0, b});
      end
      if (overrun && t == 3 * CPB + 5) bus_write(UART_TXD_OFF, {24'd0, ~b});
      else tick();
    end
    peek(UART_CON_OFF, v);
    check("tx_ovr", {31'd0, v[UCON_TX_OVR]}, overrun ? 32'd1 : 32'd0);
    tick();
  endtask

  task automatic rx_send(input logic [7:0] b, input logic stop);
    logic [9:0] frame;
    frame = {stop, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      uart_rx = frame[i];
      repeat (CPB) tick();
    end
    uart_rx = 1'b1;
    repeat (2) tick();
  endtask

  initial begin
    logic [31:0] v, th, m_tl;
    logic        m_ip;
    logic [7:0]  b;
    int          k;

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    check_all_zero("reset");

    // Timer reload and interrupt.
    bus_write(TH_OFF, 32'hFFFF_FFFC);
    bus_write(TL_OFF, 32'hFFFF_FFFE);
    bus_write(TCON_OFF, 32'd3);
    tick();
    peek(TL_OFF, v);  check("tl_ffffffff", v, 32'hFFFF_FFFF);
    check("irq_before", {31'd0, irq}, 32'd0);
    tick();
    peek(TL_OFF, v);  check("tl_reload", v, 32'hFFFF_FFFC);
    check("irq_set", {31'd0, irq}, 32'd1);
    peek(TCON_OFF, v); check("tcon_pend", v, 32'd7);
    bus_write(TCON_OFF, 32'd3);
    check("irq_clear", {31'd0, irq}, 32'd0);
    repeat (3) tick();
    check("irq_again", {31'd0, irq}, 32'd1);
    supervisor = 1'b1; #1;
    check("irq_masked", {31'd0, irq}, 32'd0);
    supervisor = 1'b0; #1;
    check("irq_unmasked", {31'd0, irq}, 32'd1);

    // Collision: TCON write on the overflow edge wins the pending bit.
    bus_write(TCON_OFF, 32'd0);
    bus_write(TH_OFF, 32'h0000_1000);
    bus_write(TL_OFF, 32'hFFFF_FFFE);
    bus_write(TCON_OFF, 32'd3);
    tick();
    bus_write(TCON_OFF, 32'd3);
    peek(TCON_OFF, v); check("coll_tcon", v, 32'd3);
    peek(TL_OFF, v);   check("coll_tcon_tl", v, 32'h0000_1000);
    // Collision: TL write on the overflow edge wins the counter.
    bus_write(TL_OFF, 32'hFFFF_FFFF);
    bus_write(TL_OFF, 32'h0000_1234);
    peek(TL_OFF, v);   check("coll_tl", v, 32'h0000_1234);
    peek(TCON_OFF, v); check("coll_tl_tcon", v, 32'd7);

    // Randomized timer runs against an arithmetic model.
    for (int rep = 0; rep < 4; rep++) begin
      th = $urandom;
      k  = $urandom_range(0, 4);
      bus_write(TCON_OFF, 32'd0);
      bus_write(TH_OFF, th);
      bus_write(TL_OFF, 32'hFFFF_FFFF - k);
      bus_write(TCON_OFF, 32'd3);
      m_tl = 32'hFFFF_FFFF - k;
      m_ip = 1'b0;
      for (int c = 0; c < 8; c++) begin
        tick();
        if (m_tl == 32'hFFFF_FFFF) begin
          m_tl = th;
          m_ip = 1'b1;
        end else m_tl = m_tl + 1;
        peek(TL_OFF, v);
        check("rand_tl", v, m_tl);
        check("rand_irq", {31'd0, irq}, {31'd0, m_ip});
      end
    end
    bus_write(TCON_OFF, 32'd0);

    // Board I/O.
    switch = 8'h5A;
    repeat (2) tick();
    peek(SWITCH_OFF, v); check("switch", v, 32'h0000_005A);
    bus_write(LED_OFF, 32'h1FF);
    check("led_out", {24'd0, led}, 32'h0000_00FF);
    peek(LED_OFF, v); check("led_read", v, 32'h0000_00FF);
    bus_write(DIGI_OFF, 32'hFFFF_FABC);
    check("digi_out", {20'd0, digi}, 32'h0000_0ABC);
    rd = 1'b0; addr = 32'h4000_000C; #1;
    check("rd_low", rdata, 32'd0);
    rd = 1'b1; addr = 32'h0000_000C; #1;
    check("addr30_low", rdata, 32'd0);
    rd = 1'b0; addr = '0;
    peek(4'h9, v); check("unmapped", v, 32'd0);
    tick();

`ifdef PERIPH_UART_EN
    // Transmit with an overrun attempt mid-frame.
    tx_frame(8'hA5, 1'b1);
    bus_write(UART_CON_OFF, 32'd0);
    peek(UART_CON_OFF, v); check("tx_ovr_clr", v, 32'd0);
    tx_frame(8'($urandom), 1'b0);

    // Receive.
    rx_send(8'h3C, 1'b1);
    peek(UART_CON_OFF, v); check("rx_con", v, 32'h04);
    peek(UART_RXD_OFF, v); check("rx_data", v, 32'h3C);
    read_edge(UART_RXD_OFF);
    peek(UART_CON_OFF, v); check("rx_vld_clr", v, 32'h00);
    for (int rep = 0; rep < 3; rep++) begin
      b = 8'($urandom);
      rx_send(b, 1'b1);
      peek(UART_RXD_OFF, v); check("rx_rand", v, {24'd0, b});
      peek(UART_CON_OFF, v); check("rx_rand_con", v, 32'h04);
      read_edge(UART_RXD_OFF);
    end

    // Overrun.
    rx_send(8'h11, 1'b1);
    rx_send(8'h22, 1'b1);
    peek(UART_RXD_OFF, v); check("rx_ovr_data", v, 32'h22);
    peek(UART_CON_OFF, v); check("rx_ovr_con", v, 32'h14);
    bus_write(UART_CON_OFF, 32'd0);
    peek(UART_CON_OFF, v); check("rx_ovr_clr", v, 32'h04);
    read_edge(UART_RXD_OFF);

    // Glitch on the line.
    uart_rx = 1'b0;
    repeat (3) tick();
    uart_rx = 1'b1;
    repeat (3 * CPB) tick();
    peek(UART_CON_OFF, v); check("glitch_con", v, 32'h00);
    peek(UART_RXD_OFF, v); check("glitch_rxd", v, 32'h22);

    // Framing error.
    rx_send(8'h77, 1'b0);
    repeat (2 * CPB) tick();
    peek(UART_CON_OFF, v); check("frame_err_con", v, 32'h00);
    peek(UART_RXD_OFF, v); check("frame_err_rxd", v, 32'h22);

    // Reset in the middle of data bit 3 of a frame.
    switch = 8'h00;
    b = 8'($urandom) & 8'hF7;
    bus_write(UART_TXD_OFF, {24'd0, b});
    repeat (4 * CPB + 3) tick();
    check("pre_reset_tx", {31'd0, uart_tx}, 32'd0);
    reset = 1'b0; #1;
    check("async_tx", {31'd0, uart_tx}, 32'd1);
    repeat (2) tick();
    reset = 1'b1;
    check_all_zero("mid_reset");
    tx_frame(8'($urandom), 1'b0);
`else
    // UART registers absent: reads return 0, writes ignored, line idles high.
    bus_write(UART_TXD_OFF, 32'hA5);
    bus_write(UART_CON_OFF, 32'hFF);
    for (int o = 6; o < 9; o++) begin
      peek(4'(o), v);
      check("no_uart_reg", v, 32'd0);
    end
    check("no_uart_tx", {31'd0, uart_tx}, 32'd1);
    tick();

    // Reset while the timer is running and registers are loaded.
    switch = 8'h00;
    bus_write(TCON_OFF, 32'd7);
    repeat (3) tick();
    reset = 1'b0; #1;
    check("async_irq", {31'd0, irq}, 32'd0);
    repeat (2) tick();
    reset = 1'b1;
    check_all_zero("mid_reset");
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
